// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file for the decode stage, with a per-register busy scoreboard
// for hazard detection.
//   - NUM_RD combinational read ports (data plus busy flag per port).
//   - One write port from writeback. With BYPASS=1, write data is forwarded
//     to a matching read port in the same cycle.
//   - A reserve port from issue marks a register busy, meaning a new
//     producer is in flight.
//   - flush clears every busy bit (pipeline squash).
//   - busy_cnt is the registered population count of the busy vector.
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   rd_addr/rd_data     packed read ports; port k at [k*W +: W]
//   rd_busy             busy flag of the register addressed by each port
//   wr_en/addr/data     write port
//   rsv_en/rsv_addr     reserve port
//   flush               clear all busy bits
//   busy_cnt            number of busy registers
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr_zero;
  logic              w_rsv_zero;
  logic              w_wr_eff;
  logic              w_rsv_eff;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Accesses to a hardwired zero register are dropped outright. This keeps
  // busy[0] constant 0 without needing a special case downstream.
  assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
  assign w_wr_eff   = wr_en && !w_wr_zero;
  assign w_rsv_eff  = rsv_en && !flush && !w_rsv_zero;

  // Apply the write clear before the reserve set, so that a reserve to the
  // same register wins (the newer producer holds it).
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_eff)  w_busy_nxt[wr_addr]  = 1'b0;
      if (w_rsv_eff) w_busy_nxt[rsv_addr] = 1'b1;
    end
  end

  // ---- storage / scoreboard register stage ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_eff) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcount(w_busy_nxt);
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Read ports. Bypass is gated with RST_N so that every port reads 0
  // while reset is held, even if a write is presented.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_byp;
    logic              w_rsv_hit;

    assign w_addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero    = (ZERO_REG != 0) && (w_addr == '0);
    assign w_byp     = (BYPASS != 0) && RST_N && w_wr_eff && (wr_addr == w_addr);
    assign w_rsv_hit = w_rsv_eff && (rsv_addr == w_addr);

    assign rd_data[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                         w_byp  ? wr_data : r_regs[w_addr];
    // A write completing this cycle releases the register, unless a new
    // producer reserves it in the same cycle.
    assign rd_busy[k] = (w_byp && !w_rsv_hit) ? 1'b0 : r_busy[w_addr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard.
// Three instances share one clock and reset:
//   - dut:    default parameters.
//   - dut_nb: the same parameters with BYPASS=0, driven by the same inputs.
//   - dut_p:  DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0.
// The reference model is a plain array of register values plus a busy flag
// per register, updated by the architectural rules.
module tb_regfile_scoreboard;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [5:0]  busy_cnt, busy_cnt_nb;

  logic [11:0] p_rd_addr;
  logic [63:0] p_rd_data;
  logic [3:0]  p_rd_busy;
  logic        p_wr_en;
  logic [2:0]  p_wr_addr;
  logic [15:0] p_wr_data;
  logic        p_rsv_en;
  logic [2:0]  p_rsv_addr;
  logic        p_flush;
  logic [3:0]  p_busy_cnt;

  regfile_scoreboard dut (
    .CLK(CLK), .RST_N(RST_N), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .RST_N(RST_N), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt_nb)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_p (
    .CLK(CLK), .RST_N(RST_N), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
    .rd_busy(p_rd_busy), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr), .flush(p_flush), .busy_cnt(p_busy_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wr_en && wr_addr == a && !(rsv_en && !flush && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!RST_N) begin
      model_reset();
      return;
    end
    if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] = wr_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    p_wr_en = 1'b0; p_rsv_en = 1'b0; p_flush = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0; p_rsv_addr = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (rd_data !== 64'd0) begin n_err++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b want 00", rd_busy); end
    n_cmp++; if (p_busy_cnt !== 4'd0) begin n_err++; $display("FAIL reset_pcnt: got %0d want 0", p_busy_cnt); end
    RST_N = 1'b1;
    // Preload r5, also reserving it, then abort with an asynchronous reset.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL preload_r5: got %h want deadbeef", rd_data[31:0]); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL preload_cnt: got %0d want 1", busy_cnt); end
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL preload_busy: got %b want 11", rd_busy); end
    #1 RST_N = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 64'd0) begin n_err++; $display("FAIL async_rst_rd: got %h want 0", rd_data); end
    n_cmp++; if (rd_data_nb !== 64'd0) begin n_err++; $display("FAIL async_rst_rd_nb: got %h want 0", rd_data_nb); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL async_rst_busy: got %b want 00", rd_busy); end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_write_zero();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    tick();
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    idle();
    rd_addr = {5'd0, 5'd3};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h12345678) begin n_err++; $display("FAIL wr_r3: got %h want 12345678", rd_data[31:0]); end
    n_cmp++; if (rd_data[63:32] !== 32'd0) begin n_err++; $display("FAIL wr_r0: got %h want 0", rd_data[63:32]); end
    n_cmp++; if (rd_data_nb !== {32'd0, 32'h12345678}) begin n_err++; $display("FAIL wr_nb: got %h want 0000000012345678", rd_data_nb); end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    tick();
    idle();
    rd_addr = {5'd0, 5'd7};
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_fwd: got %h want a5a5a5a5", rd_data[31:0]); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h11111111) begin n_err++; $display("FAIL nobypass_old: got %h want 11111111", rd_data_nb[31:0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd_data_nb[31:0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL nobypass_new: got %h want a5a5a5a5", rd_data_nb[31:0]); end
  endtask

  task automatic test_scoreboard();
    flush = 1'b1;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_addr = 5'd9;
    tick();
    idle();
    rd_addr = {5'd9, 5'd4};
    #1;
    n_cmp++; if (busy_cnt !== 6'd2) begin n_err++; $display("FAIL sb_cnt2: got %0d want 2", busy_cnt); end
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL sb_busy: got %b want 11", rd_busy); end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000044;
    #1;
    n_cmp++; if (rd_busy !== 2'b10) begin n_err++; $display("FAIL sb_wr_release: got %b want 10", rd_busy); end
    n_cmp++; if (rd_busy_nb !== 2'b11) begin n_err++; $display("FAIL sb_wr_nb: got %b want 11", rd_busy_nb); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt1: got %0d want 1", busy_cnt); end
    n_cmp++; if (busy_cnt_nb !== 6'd1) begin n_err++; $display("FAIL sb_cnt1_nb: got %0d want 1", busy_cnt_nb); end
    n_cmp++; if (rd_busy !== 2'b10) begin n_err++; $display("FAIL sb_after: got %b want 10", rd_busy); end
  endtask

  task automatic test_simultaneous();
    // r9 is still busy; add r6.
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    rd_addr = {5'd6, 5'd6};
    #1;
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL sim_busy_pre: got %b want 11", rd_busy); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_cnt !== 6'd2) begin n_err++; $display("FAIL sim_cnt: got %0d want 2", busy_cnt); end
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL sim_busy_post: got %b want 11", rd_busy); end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000CAFE;
    rd_addr = {5'd10, 5'd10};
    #1;
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL flush_busy_pre: got %b want 00", rd_busy); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL flush_r10: got %b want 00", rd_busy); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h0000CAFE) begin n_err++; $display("FAIL flush_write: got %h want 0000cafe", rd_data_nb[31:0]); end
  endtask

  // Half the addresses come from a small pool so that collisions between
  // the read, write and reserve ports are frequent.
  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic test_random();
    logic [4:0] a;
    for (int it = 0; it < 400; it++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = pick_addr();
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : pick_addr();
      flush    = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 2; k++) begin
        rd_addr[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : pick_addr();
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        n_cmp++;
        if (rd_data[k*32 +: 32] !== exp_data(a, 1'b1)) begin
          n_err++; $display("FAIL rnd_data it=%0d port=%0d addr=%0d: got %h want %h", it, k, a, rd_data[k*32 +: 32], exp_data(a, 1'b1));
        end
        n_cmp++;
        if (rd_data_nb[k*32 +: 32] !== exp_data(a, 1'b0)) begin
          n_err++; $display("FAIL rnd_data_nb it=%0d port=%0d addr=%0d: got %h want %h", it, k, a, rd_data_nb[k*32 +: 32], exp_data(a, 1'b0));
        end
        n_cmp++;
        if (rd_busy[k] !== exp_busy(a, 1'b1)) begin
          n_err++; $display("FAIL rnd_busy it=%0d port=%0d addr=%0d: got %b want %b", it, k, a, rd_busy[k], exp_busy(a, 1'b1));
        end
        n_cmp++;
        if (rd_busy_nb[k] !== exp_busy(a, 1'b0)) begin
          n_err++; $display("FAIL rnd_busy_nb it=%0d port=%0d addr=%0d: got %b want %b", it, k, a, rd_busy_nb[k], exp_busy(a, 1'b0));
        end
      end
      tick();
      n_cmp++;
      if (busy_cnt !== 6'(m_count())) begin
        n_err++; $display("FAIL rnd_cnt it=%0d: got %0d want %0d", it, busy_cnt, m_count());
      end
      n_cmp++;
      if (busy_cnt_nb !== 6'(m_count())) begin
        n_err++; $display("FAIL rnd_cnt_nb it=%0d: got %0d want %0d", it, busy_cnt_nb, m_count());
      end
    end
    idle();
  endtask

  task automatic test_parametric();
    idle();
    p_wr_en = 1'b1; p_wr_addr = 3'd0; p_wr_data = 16'h00FF;
    tick();
    idle();
    p_rd_addr = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (p_rd_data[k*16 +: 16] !== 16'h00FF) begin
        n_err++; $display("FAIL p_r0_port%0d: got %h want 00ff", k, p_rd_data[k*16 +: 16]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      p_rsv_en = 1'b1; p_rsv_addr = 3'(i);
      tick();
    end
    idle();
    p_rd_addr = {3'd7, 3'd5, 3'd2, 3'd0};
    #1;
    n_cmp++; if (p_busy_cnt !== 4'd8) begin n_err++; $display("FAIL p_cnt8: got %0d want 8", p_busy_cnt); end
    n_cmp++; if (p_rd_busy !== 4'hF) begin n_err++; $display("FAIL p_busy_all: got %b want 1111", p_rd_busy); end
    p_flush = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (p_busy_cnt !== 4'd0) begin n_err++; $display("FAIL p_flush: got %0d want 0", p_busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_zero();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_random();
    test_parametric();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
